// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
//   Hardwired control unit for the CPU datapath. A Moore FSM steps through
//   fetch (T0-T2) and execute (T3-T7) for the supported instruction subset
//   and decodes every datapath control line from the registered step and IR.
//   Memory steps stall on mem_ready and fault into HALT after MEM_TIMEOUT
//   cycles without a response.
//
// Ports
//   clk          system clock, rising edge
//   clr          asynchronous active-low reset
//   run          leave IDLE and start fetching
//   ir[31:0]     IR contents: opcode[31:27] Ra[26:23] Rb[22:19] Rc[18:15] C[18:0]
//   mem_ready    memory finished the current read/write
//   reg_out      one-hot register-to-bus select
//   reg_in       one-hot register enable
//   pc_out, zlo_out, zhi_out, mdr_out, c_out            bus drivers
//   mar_enable, z_enable, y_enable, ir_enable,
//   mdr_enable, hi_enable, lo_enable, pc_increment      register strobes
//   read, write  memory strobes (read also selects memory into the MDR)
//   op_code      ALU operation
//   c_sign_ext   C field sign-extended to 32 bits
//   halted       high while in HALT
//   illegal      one-cycle pulse on an undefined opcode
//   mem_fault    sticky memory-timeout flag
// ---------------------------------------------------------------------------
module control_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        run,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic [15:0] reg_out,
    output logic [15:0] reg_in,
    output logic        pc_out,
    output logic        zlo_out,
    output logic        zhi_out,
    output logic        mdr_out,
    output logic        c_out,
    output logic        mar_enable,
    output logic        z_enable,
    output logic        y_enable,
    output logic        ir_enable,
    output logic        mdr_enable,
    output logic        hi_enable,
    output logic        lo_enable,
    output logic        pc_increment,
    output logic        read,
    output logic        write,
    output logic [4:0]  op_code,
    output logic [31:0] c_sign_ext,
    output logic        halted,
    output logic        illegal,
    output logic        mem_fault
);

    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               mem_fault_q, mem_fault_d;

    // IR field decode
    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       is_rtype, is_addi, is_muldiv, is_ld, is_st, is_nop, is_halt, is_illegal;
    logic       wait_step;

    assign opcode     = ir[31:27];
    assign ra         = ir[26:23];
    assign rb         = ir[22:19];
    assign rc         = ir[18:15];
    assign c_sign_ext = {{13{ir[18]}}, ir[18:0]};

    assign is_rtype   = (opcode <= 5'b01011);
    assign is_addi    = (opcode == 5'b01100);
    assign is_muldiv  = (opcode == 5'b01111) || (opcode == 5'b10000);
    assign is_ld      = (opcode == 5'b10001);
    assign is_st      = (opcode == 5'b10010);
    assign is_nop     = (opcode == 5'b11010);
    assign is_halt    = (opcode == 5'b11011);
    assign is_illegal = !(is_rtype || is_addi || is_muldiv || is_ld || is_st || is_nop || is_halt);

    // Steps that stall on memory: fetch read, ld data read, st write
    assign wait_step  = (state_q == S_T1) ||
                        ((state_q == S_T6) && is_ld) ||
                        ((state_q == S_T7) && is_st);

    // Next-state, wait counter and fault flag
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_fault_d = mem_fault_q;

        case (state_q)
            S_IDLE: if (run) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3: begin
                if (is_halt)                 state_d = S_HALT;
                else if (is_nop || is_illegal) state_d = S_T0;
                else                         state_d = S_T4;
            end
            S_T4:   state_d = S_T5;
            S_T5:   state_d = (is_rtype || is_addi) ? S_T0 : S_T6;
            S_T6:   state_d = is_muldiv ? S_T0 : S_T7;
            S_T7:   state_d = S_T0;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase

        // A wait step overrides the normal advance until memory responds;
        // the last stalled cycle before the timeout diverts to HALT instead.
        if (wait_step) begin
            if (mem_ready) begin
                wait_cnt_d = '0;
            end else if (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                wait_cnt_d  = '0;
                mem_fault_d = 1'b1;
                state_d     = S_HALT;
            end else begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                state_d    = state_q;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= '0;
            mem_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_fault_q <= mem_fault_d;
        end
    end

    // Moore output decode from the registered step plus IR
    always_comb begin
        reg_out      = '0;
        reg_in       = '0;
        pc_out       = 1'b0;
        zlo_out      = 1'b0;
        zhi_out      = 1'b0;
        mdr_out      = 1'b0;
        c_out        = 1'b0;
        mar_enable   = 1'b0;
        z_enable     = 1'b0;
        y_enable     = 1'b0;
        ir_enable    = 1'b0;
        mdr_enable   = 1'b0;
        hi_enable    = 1'b0;
        lo_enable    = 1'b0;
        pc_increment = 1'b0;
        read         = 1'b0;
        write        = 1'b0;
        op_code      = '0;
        halted       = 1'b0;
        illegal      = 1'b0;

        case (state_q)
            S_T0: begin
                pc_out       = 1'b1;
                mar_enable   = 1'b1;
                pc_increment = 1'b1;
            end
            S_T1: begin
                read       = 1'b1;
                mdr_enable = 1'b1;
            end
            S_T2: begin
                mdr_out   = 1'b1;
                ir_enable = 1'b1;
            end
            S_T3: begin
                if (is_muldiv) begin
                    reg_out  = 16'd1 << ra;
                    y_enable = 1'b1;
                end else if (is_rtype || is_addi || is_ld || is_st) begin
                    reg_out  = 16'd1 << rb;
                    y_enable = 1'b1;
                end
                illegal = is_illegal;
            end
            S_T4: begin
                z_enable = 1'b1;
                if (is_rtype) begin
                    reg_out = 16'd1 << rc;
                    op_code = opcode;
                end else if (is_muldiv) begin
                    reg_out = 16'd1 << rb;
                    op_code = opcode;
                end else begin
                    c_out = 1'b1;
                end
            end
            S_T5: begin
                zlo_out = 1'b1;
                if (is_muldiv)          lo_enable  = 1'b1;
                else if (is_ld || is_st) mar_enable = 1'b1;
                else                    reg_in     = 16'd1 << ra;
            end
            S_T6: begin
                if (is_muldiv) begin
                    zhi_out   = 1'b1;
                    hi_enable = 1'b1;
                end else if (is_ld) begin
                    read       = 1'b1;
                    mdr_enable = 1'b1;
                end else begin
                    reg_out    = 16'd1 << ra;
                    mdr_enable = 1'b1;
                end
            end
            S_T7: begin
                mdr_out = 1'b1;
                if (is_st) write  = 1'b1;
                else       reg_in = 16'd1 << ra;
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    assign mem_fault = mem_fault_q;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        clr, run, mem_ready;
    logic [31:0] ir;
    logic [15:0] reg_out, reg_in;
    logic        pc_out, zlo_out, zhi_out, mdr_out, c_out;
    logic        mar_enable, z_enable, y_enable, ir_enable, mdr_enable;
    logic        hi_enable, lo_enable, pc_increment, read, write;
    logic [4:0]  op_code;
    logic [31:0] c_sign_ext;
    logic        halted, illegal, mem_fault;

    always #5 clk = ~clk;

    control_sequencer #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .clr(clr), .run(run), .ir(ir), .mem_ready(mem_ready),
        .reg_out(reg_out), .reg_in(reg_in),
        .pc_out(pc_out), .zlo_out(zlo_out), .zhi_out(zhi_out),
        .mdr_out(mdr_out), .c_out(c_out),
        .mar_enable(mar_enable), .z_enable(z_enable), .y_enable(y_enable),
        .ir_enable(ir_enable), .mdr_enable(mdr_enable), .hi_enable(hi_enable),
        .lo_enable(lo_enable), .pc_increment(pc_increment),
        .read(read), .write(write), .op_code(op_code), .c_sign_ext(c_sign_ext),
        .halted(halted), .illegal(illegal), .mem_fault(mem_fault)
    );

    // Control-word bit positions (op_code occupies [22:18])
    localparam logic [22:0] PC_O = 23'h00001, ZLO_O = 23'h00002, ZHI_O = 23'h00004;
    localparam logic [22:0] MDR_O = 23'h00008, C_O = 23'h00010, MAR_E = 23'h00020;
    localparam logic [22:0] Z_E = 23'h00040, Y_E = 23'h00080, IR_E = 23'h00100;
    localparam logic [22:0] MDR_E = 23'h00200, HI_E = 23'h00400, LO_E = 23'h00800;
    localparam logic [22:0] PC_INC = 23'h01000, RD = 23'h02000, WR = 23'h04000;
    localparam logic [22:0] HLT = 23'h08000, ILL = 23'h10000, MFLT = 23'h20000;
    localparam logic [22:0] FT0 = PC_O | MAR_E | PC_INC;
    localparam logic [22:0] FT1 = RD | MDR_E;
    localparam logic [22:0] FT2 = MDR_O | IR_E;
    localparam logic [22:0] OP_MUL = {5'b01111, 18'b0};

    localparam logic [31:0] ADD  = 32'h029A0000; // add R5,R3,R4
    localparam logic [31:0] LD   = 32'h8897FFFF; // ld  R1,0x7FFFF(R2)
    localparam logic [31:0] MUL  = 32'h79880000; // mul R3,R1
    localparam logic [31:0] ST   = 32'h93380010; // st  R6,0x10(R7)
    localparam logic [31:0] BAD  = 32'hF8000000; // opcode 11111
    localparam logic [31:0] NOP  = 32'hD0000000;
    localparam logic [31:0] HALTI = 32'hD8000000;

    typedef struct {
        logic        run;
        logic [31:0] ir;
        logic        rdy;
        logic [15:0] ro;
        logic [15:0] ri;
        logic [22:0] ctl;
    } vec_t;

    vec_t tbl [47];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    function automatic vec_t v(input logic r, input logic [31:0] i, input logic m,
                               input logic [15:0] o, input logic [15:0] n,
                               input logic [22:0] c);
        vec_t t;
        t.run = r; t.ir = i; t.rdy = m; t.ro = o; t.ri = n; t.ctl = c;
        return t;
    endfunction

    function automatic logic [54:0] outs();
        return {reg_out, reg_in, op_code, mem_fault, illegal, halted, write, read,
                pc_increment, lo_enable, hi_enable, mdr_enable, ir_enable, y_enable,
                z_enable, mar_enable, c_out, mdr_out, zhi_out, zlo_out, pc_out};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string name, input logic [15:0] ro,
                            input logic [15:0] ri, input logic [22:0] ctl);
        chk(name, {9'b0, outs()}, {9'b0, ro, ri, ctl});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // One cycle per row: inputs applied after the rising edge, outputs
        // sampled on the falling edge.
        tbl[0]  = v(0, ADD, 1, 16'h0000, 16'h0000, '0);
        tbl[1]  = v(1, ADD, 1, 16'h0000, 16'h0000, '0);
        tbl[2]  = v(0, ADD, 1, 16'h0000, 16'h0000, FT0);
        tbl[3]  = v(0, ADD, 1, 16'h0000, 16'h0000, FT1);
        tbl[4]  = v(0, ADD, 1, 16'h0000, 16'h0000, FT2);
        tbl[5]  = v(0, ADD, 1, 16'h0008, 16'h0000, Y_E);
        tbl[6]  = v(0, ADD, 1, 16'h0010, 16'h0000, Z_E);
        tbl[7]  = v(0, ADD, 1, 16'h0000, 16'h0020, ZLO_O);
        tbl[8]  = v(0, LD,  1, 16'h0000, 16'h0000, FT0);
        tbl[9]  = v(0, LD,  1, 16'h0000, 16'h0000, FT1);
        tbl[10] = v(0, LD,  1, 16'h0000, 16'h0000, FT2);
        tbl[11] = v(0, LD,  1, 16'h0004, 16'h0000, Y_E);
        tbl[12] = v(0, LD,  1, 16'h0000, 16'h0000, C_O | Z_E);
        tbl[13] = v(0, LD,  1, 16'h0000, 16'h0000, ZLO_O | MAR_E);
        tbl[14] = v(0, LD,  0, 16'h0000, 16'h0000, RD | MDR_E);
        tbl[15] = v(0, LD,  0, 16'h0000, 16'h0000, RD | MDR_E);
        tbl[16] = v(0, LD,  0, 16'h0000, 16'h0000, RD | MDR_E);
        tbl[17] = v(0, LD,  1, 16'h0000, 16'h0000, RD | MDR_E);
        tbl[18] = v(0, LD,  1, 16'h0000, 16'h0002, MDR_O);
        tbl[19] = v(0, MUL, 1, 16'h0000, 16'h0000, FT0);
        tbl[20] = v(0, MUL, 1, 16'h0000, 16'h0000, FT1);
        tbl[21] = v(0, MUL, 1, 16'h0000, 16'h0000, FT2);
        tbl[22] = v(0, MUL, 1, 16'h0008, 16'h0000, Y_E);
        tbl[23] = v(0, MUL, 1, 16'h0002, 16'h0000, Z_E | OP_MUL);
        tbl[24] = v(0, MUL, 1, 16'h0000, 16'h0000, ZLO_O | LO_E);
        tbl[25] = v(0, MUL, 1, 16'h0000, 16'h0000, ZHI_O | HI_E);
        tbl[26] = v(0, ST,  1, 16'h0000, 16'h0000, FT0);
        tbl[27] = v(0, ST,  1, 16'h0000, 16'h0000, FT1);
        tbl[28] = v(0, ST,  1, 16'h0000, 16'h0000, FT2);
        tbl[29] = v(0, ST,  1, 16'h0080, 16'h0000, Y_E);
        tbl[30] = v(0, ST,  1, 16'h0000, 16'h0000, C_O | Z_E);
        tbl[31] = v(0, ST,  1, 16'h0000, 16'h0000, ZLO_O | MAR_E);
        tbl[32] = v(0, ST,  1, 16'h0040, 16'h0000, MDR_E);
        tbl[33] = v(0, ST,  0, 16'h0000, 16'h0000, MDR_O | WR);
        tbl[34] = v(0, ST,  1, 16'h0000, 16'h0000, MDR_O | WR);
        tbl[35] = v(0, BAD, 1, 16'h0000, 16'h0000, FT0);
        tbl[36] = v(0, BAD, 1, 16'h0000, 16'h0000, FT1);
        tbl[37] = v(0, BAD, 1, 16'h0000, 16'h0000, FT2);
        tbl[38] = v(0, BAD, 1, 16'h0000, 16'h0000, ILL);
        tbl[39] = v(0, NOP, 1, 16'h0000, 16'h0000, FT0);
        tbl[40] = v(0, NOP, 1, 16'h0000, 16'h0000, FT1);
        tbl[41] = v(0, NOP, 1, 16'h0000, 16'h0000, FT2);
        tbl[42] = v(0, NOP, 1, 16'h0000, 16'h0000, '0);
        tbl[43] = v(0, HALTI, 1, 16'h0000, 16'h0000, FT0);
        tbl[44] = v(0, HALTI, 1, 16'h0000, 16'h0000, FT1);
        tbl[45] = v(0, HALTI, 1, 16'h0000, 16'h0000, FT2);
        tbl[46] = v(0, HALTI, 1, 16'h0000, 16'h0000, '0);

        clr = 1'b0; run = 1'b0; ir = ADD; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 clr = 1'b1;

        for (int i = 0; i < 47; i++) begin
            run = tbl[i].run; ir = tbl[i].ir; mem_ready = tbl[i].rdy;
            @(negedge clk);
            chk_outs($sformatf("row%0d", i), tbl[i].ro, tbl[i].ri, tbl[i].ctl);
            @(posedge clk); #1;
        end

        // HALT is sticky regardless of run
        for (int i = 0; i < 100; i++) begin
            run = i[0];
            @(negedge clk);
            chk_outs($sformatf("halt%0d", i), 16'h0, 16'h0, HLT);
            @(posedge clk); #1;
        end

        // Reset out of HALT, then reset mid-T4 of an add
        clr = 1'b0; #1;
        chk_outs("rst_halt", 16'h0, 16'h0, '0);
        clr = 1'b1; run = 1'b1; ir = ADD; mem_ready = 1'b1;
        @(posedge clk); #1 run = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk_outs("add_t4", 16'h0010, 16'h0, Z_E);
        clr = 1'b0; #1;
        chk_outs("rst_async", 16'h0, 16'h0, '0);
        @(posedge clk); #1 clr = 1'b1;
        @(negedge clk);
        chk_outs("rst_idle", 16'h0, 16'h0, '0);
        run = 1'b1;
        @(posedge clk); #1 run = 1'b0;
        @(negedge clk);
        chk_outs("rst_t0", 16'h0, 16'h0, FT0);

        // Fetch read never answered: 15 stalled cycles then fault
        mem_ready = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk_outs($sformatf("to_t1_%0d", i), 16'h0, 16'h0, FT1);
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_outs($sformatf("to_halt%0d", i), 16'h0, 16'h0, HLT | MFLT);
            @(posedge clk); #1;
        end
        clr = 1'b0; #1;
        chk_outs("to_clr", 16'h0, 16'h0, '0);
        #1 clr = 1'b1;
        @(negedge clk);
        chk_outs("to_idle", 16'h0, 16'h0, '0);

        // 14 stalled cycles is one short of the timeout
        run = 1'b1; mem_ready = 1'b0;
        @(posedge clk); #1 run = 1'b0;
        @(posedge clk); #1;
        repeat (14) @(posedge clk);
        #1 mem_ready = 1'b1;
        @(negedge clk);
        chk_outs("w14_t1", 16'h0, 16'h0, FT1);
        @(posedge clk); #1;
        @(negedge clk);
        chk_outs("w14_t2", 16'h0, 16'h0, FT2);

        // Sign extension of C
        ir = LD;            #1 chk("csx_neg1", {32'h0, c_sign_ext}, 64'h0000_0000_FFFF_FFFF);
        ir = 32'h00040000;  #1 chk("csx_min",  {32'h0, c_sign_ext}, 64'h0000_0000_FFFC_0000);
        ir = 32'h0003FFFF;  #1 chk("csx_max",  {32'h0, c_sign_ext}, 64'h0000_0000_0003_FFFF);
        ir = 32'hFFF80000;  #1 chk("csx_zero", {32'h0, c_sign_ext}, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
